// File: rtl/ircam_frame_ctrl.sv
// Double-buffered IR frame capture: streams pixels into one of two banks and
// offers completed frames to a consumer through a claim/release handshake.
module ircam_frame_ctrl #(
    parameter int PIX_PER_FRAME = 768
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sof,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        rd_start,
    input  logic        rd_done,
    output logic        wr_en,
    output logic        wr_bank,
    output logic [9:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        frame_ready,
    output logic        rd_bank,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_t;
    typedef enum logic {S_IDLE, S_CAPTURE} state_t;

    state_t     state, state_nxt;
    bank_st_t   bank [2];
    bank_st_t   bank_nxt [2];
    logic       fill_bank, last_wr_bank;
    logic [9:0] pix_cnt, cnt_now;
    logic       any_empty, pick_bank, start, drop, act_bank, accept, last_pix;
    logic       ready_now, offer_now, ready_post, offer_post;

    // {ready, bank}: the oldest FULL bank is offered only while nothing is being read
    function automatic logic [1:0] offer(input bank_st_t b0, input bank_st_t b1, input logic last);
        logic f0, f1, rdg;
        f0  = (b0 == B_FULL);
        f1  = (b1 == B_FULL);
        rdg = (b0 == B_READING) || (b1 == B_READING);
        return {!rdg && (f0 || f1), (f0 && f1) ? ~last : f1};
    endfunction

    assign {ready_now, offer_now} = offer(bank[0], bank[1], last_wr_bank);
    assign frame_ready = ready_now;
    assign rd_bank = (bank[1] == B_READING) ? 1'b1 :
                     (bank[0] == B_READING) ? 1'b0 : offer_now;

    always_comb begin
        any_empty = (bank[0] == B_EMPTY) || (bank[1] == B_EMPTY);
        pick_bank = (bank[0] == B_EMPTY && bank[1] == B_EMPTY) ? ~last_wr_bank
                                                               : (bank[0] != B_EMPTY);
        start     = sof && (state == S_IDLE) && any_empty;
        drop      = sof && !start;
        act_bank  = start ? pick_bank : fill_bank;
        cnt_now   = sof ? '0 : pix_cnt;
        accept    = pix_valid && (start || state == S_CAPTURE);
        last_pix  = accept && (cnt_now == 10'(PIX_PER_FRAME - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && !last_pix) state_nxt = S_CAPTURE;
            S_CAPTURE: if (last_pix) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_CAPTURE);
    end

    // Release happens before claim, so a same-cycle rd_done/rd_start hands over the other bank.
    // The write side decides on the registered bank states, so a freed bank waits a cycle.
    always_comb begin
        bank_nxt = bank;
        if (rd_done) begin
            for (int b = 0; b < 2; b++)
                if (bank_nxt[b] == B_READING) bank_nxt[b] = B_EMPTY;
        end
        {ready_post, offer_post} = offer(bank_nxt[0], bank_nxt[1], last_wr_bank);
        if (rd_start && ready_post) bank_nxt[offer_post] = B_READING;
        if (start) bank_nxt[pick_bank] = B_FILLING;
        if (last_pix) bank_nxt[act_bank] = B_FULL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bank[0]      <= B_EMPTY;
            bank[1]      <= B_EMPTY;
            fill_bank    <= 1'b0;
            last_wr_bank <= 1'b1;
            pix_cnt      <= '0;
            wr_en        <= 1'b0;
            wr_bank      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_cnt    <= '0;
            drop_cnt     <= '0;
        end else begin
            state     <= state_nxt;
            bank[0]   <= bank_nxt[0];
            bank[1]   <= bank_nxt[1];
            fill_bank <= act_bank;
            pix_cnt   <= cnt_now + 10'(accept);
            wr_en     <= accept;
            if (accept) begin
                wr_bank <= act_bank;
                wr_addr <= cnt_now;
                wr_data <= pix_data;
            end
            if (last_pix) begin
                last_wr_bank <= act_bank;
                frame_cnt    <= frame_cnt + 16'd1;
            end
            if (drop) drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_ircam_frame_ctrl.sv
// Bench for ircam_frame_ctrl: directed table, frame-level sequences and random
// traffic checked every cycle against a queue-based reference model.
module tb_ircam_frame_ctrl;
    localparam int PPF = 768;

    logic        clk = 1'b0;
    logic        rst = 1'b0, sof = 1'b0, pix_valid = 1'b0, rd_start = 1'b0, rd_done = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        wr_en, wr_bank, frame_ready, rd_bank, busy;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [15:0] frame_cnt, drop_cnt;

    always #5 clk = ~clk;

    ircam_frame_ctrl #(.PIX_PER_FRAME(PPF)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .rd_start(rd_start), .rd_done(rd_done), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr(wr_addr), .wr_data(wr_data), .frame_ready(frame_ready), .rd_bank(rd_bank),
        .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    int vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: banks are described by where they sit (filling, in the
    // committed-frame queue in commit order, or being read), not by a state code.
    int          m_full[$];
    int          m_reading, m_fill, m_cnt, m_last;
    bit          m_cap, m_wr_en;
    int          m_wr_bank, m_wr_addr, m_wr_data;
    logic [15:0] m_fc, m_dc;

    function automatic bit m_empty(int b);
        if (m_cap && m_fill == b) return 0;
        if (m_reading == b) return 0;
        foreach (m_full[i]) if (m_full[i] == b) return 0;
        return 1;
    endfunction

    task automatic model_step();
        bit e0, e1;
        if (rst) begin
            m_full.delete();
            m_reading = -1; m_cap = 0; m_cnt = 0; m_last = 1; m_fill = 0;
            m_wr_en = 0; m_wr_bank = 0; m_wr_addr = 0; m_wr_data = 0; m_fc = 0; m_dc = 0;
            return;
        end
        e0 = m_empty(0);
        e1 = m_empty(1);
        if (rd_done && m_reading >= 0) m_reading = -1;
        if (rd_start && m_reading < 0 && m_full.size() > 0) m_reading = m_full.pop_front();
        m_wr_en = 0;
        if (sof) begin
            if (m_cap) begin
                m_dc++;
                m_cnt = 0;
            end else if (e0 || e1) begin
                m_fill = (e0 && e1) ? 1 - m_last : (e0 ? 0 : 1);
                m_cap = 1;
                m_cnt = 0;
            end else m_dc++;
        end
        if (pix_valid && m_cap) begin
            m_wr_en = 1; m_wr_bank = m_fill; m_wr_addr = m_cnt; m_wr_data = pix_data;
            m_cnt++;
            if (m_cnt == PPF) begin
                m_full.push_back(m_fill);
                m_last = m_fill;
                m_fc++;
                m_cap = 0;
            end
        end
    endtask

    task automatic compare_model();
        int e_rdb;
        e_rdb = (m_reading >= 0) ? m_reading : (m_full.size() > 0 ? m_full[0] : 0);
        check("m.wr_en", wr_en, m_wr_en);
        check("m.wr_bank", wr_bank, m_wr_bank);
        check("m.wr_addr", wr_addr, m_wr_addr);
        check("m.wr_data", wr_data, m_wr_data);
        check("m.frame_ready", frame_ready, (m_reading < 0 && m_full.size() > 0));
        check("m.rd_bank", rd_bank, e_rdb);
        check("m.busy", busy, m_cap);
        check("m.frame_cnt", frame_cnt, m_fc);
        check("m.drop_cnt", drop_cnt, m_dc);
    endtask

    // Inputs are held across the edge; the model samples the same values the DUT does.
    task automatic drive(bit s, bit v, logic [7:0] d, bit rs, bit rdn, bit r);
        sof = s; pix_valid = v; pix_data = d; rd_start = rs; rd_done = rdn; rst = r;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle(); drive(0, 0, 8'h00, 0, 0, 0); endtask

    task automatic do_reset(string tag);
        drive(0, 0, 8'h00, 0, 0, 1);
        drive(0, 0, 8'h00, 0, 0, 1);
        check({tag, ".rst.wr_en"}, wr_en, 0);
        check({tag, ".rst.wr_addr"}, wr_addr, 0);
        check({tag, ".rst.wr_data"}, wr_data, 0);
        check({tag, ".rst.ready"}, frame_ready, 0);
        check({tag, ".rst.rd_bank"}, rd_bank, 0);
        check({tag, ".rst.busy"}, busy, 0);
        check({tag, ".rst.cnts"}, {frame_cnt, drop_cnt}, 0);
    endtask

    // Streams n pixels and checks each write lands in bank b at consecutive addresses.
    task automatic pixels(int n, bit b, string tag);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            drive(0, 1, d, 0, 0, 0);
            if (wr_en !== 1'b1 || wr_bank !== b || wr_addr !== 10'(i) || wr_data !== d)
                check({tag, ".write"}, {wr_en, wr_bank, wr_addr, wr_data}, {1'b1, b, 10'(i), d});
        end
        vectors++;
    endtask

    typedef struct {
        bit sof, pv; logic [7:0] pd; bit rs, rd;
        bit e_en; logic [9:0] e_addr; logic [7:0] e_data; bit e_busy, e_ready; logic [15:0] e_drop;
    } vec_t;

    initial begin
        vec_t tbl[9];
        tbl[0] = '{1, 0, 8'h00, 0, 0,  0, 10'd0, 8'h00, 1, 0, 16'd0};
        tbl[1] = '{0, 1, 8'h11, 0, 0,  1, 10'd0, 8'h11, 1, 0, 16'd0};
        tbl[2] = '{0, 1, 8'h22, 0, 0,  1, 10'd1, 8'h22, 1, 0, 16'd0};
        tbl[3] = '{0, 0, 8'h00, 1, 0,  0, 10'd1, 8'h22, 1, 0, 16'd0};
        tbl[4] = '{1, 1, 8'h33, 0, 0,  1, 10'd0, 8'h33, 1, 0, 16'd1};
        tbl[5] = '{0, 1, 8'h44, 0, 0,  1, 10'd1, 8'h44, 1, 0, 16'd1};
        tbl[6] = '{0, 0, 8'h00, 0, 1,  0, 10'd1, 8'h44, 1, 0, 16'd1};
        tbl[7] = '{1, 0, 8'h00, 0, 0,  0, 10'd1, 8'h44, 1, 0, 16'd2};
        tbl[8] = '{0, 1, 8'h55, 1, 1,  1, 10'd0, 8'h55, 1, 0, 16'd2};

        do_reset("tbl");
        foreach (tbl[i]) begin
            drive(tbl[i].sof, tbl[i].pv, tbl[i].pd, tbl[i].rs, tbl[i].rd, 0);
            check($sformatf("tbl%0d.wr_en", i), wr_en, tbl[i].e_en);
            check($sformatf("tbl%0d.wr_addr", i), wr_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d.wr_data", i), wr_data, tbl[i].e_data);
            check($sformatf("tbl%0d.busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d.ready", i), frame_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d.drop", i), drop_cnt, tbl[i].e_drop);
        end

        // One full frame into bank 0, then claim it and capture the next into bank 1
        do_reset("full");
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(PPF, 0, "full");
        idle();
        check("full.ready", frame_ready, 1);
        check("full.rd_bank", rd_bank, 0);
        check("full.frame_cnt", frame_cnt, 1);
        check("full.busy", busy, 0);
        drive(0, 0, 8'h00, 1, 0, 0);
        check("claim.ready_fall", frame_ready, 0);
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(PPF, 1, "claim");
        for (int i = 0; i < 3; i++) begin
            idle();
            check("claim.ready_held", frame_ready, 0);
        end
        drive(0, 0, 8'h00, 0, 1, 0);
        check("release.ready", frame_ready, 1);
        check("release.rd_bank", rd_bank, 1);
        check("release.frame_cnt", frame_cnt, 2);

        // Both banks full, a third frame is dropped
        do_reset("drop");
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(PPF, 0, "drop.f0");
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(PPF, 1, "drop.f1");
        drive(1, 0, 8'h00, 0, 0, 0);
        check("drop.drop_cnt", drop_cnt, 1);
        check("drop.busy", busy, 0);
        drive(0, 1, 8'hA5, 0, 0, 0);
        check("drop.no_write", wr_en, 0);
        check("drop.rd_bank", rd_bank, 0);
        check("drop.ready", frame_ready, 1);
        check("drop.frame_cnt", frame_cnt, 2);

        // Short frame restarts the same bank
        do_reset("short");
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(100, 0, "short.a");
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(PPF, 0, "short.b");
        idle();
        check("short.drop_cnt", drop_cnt, 1);
        check("short.frame_cnt", frame_cnt, 1);
        check("short.rd_bank", rd_bank, 0);

        // Reset in the middle of a capture
        do_reset("mid");
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(400, 0, "mid.a");
        drive(0, 1, 8'h77, 0, 0, 1);
        check("mid.rst.outs", {wr_en, wr_bank, wr_addr, wr_data, frame_ready, rd_bank, busy}, 0);
        check("mid.rst.cnts", {frame_cnt, drop_cnt}, 0);
        drive(1, 0, 8'h00, 0, 0, 0);
        pixels(50, 0, "mid.b");
        check("mid.frame_cnt", frame_cnt, 0);
        check("mid.busy", busy, 1);

        // Random traffic against the model
        do_reset("rnd");
        for (int i = 0; i < 20000; i++)
            drive($urandom_range(0, 1199) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0,
                  $urandom_range(0, 9999) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
